// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the fetch stage.
//   word_t        : 32-bit machine word
//   opcode_t      : 6-bit primary opcode field (instr[31:26])
//   fetch_state_t : fetch FSM states
//   ifid_t        : contents of the IF/ID register and of the fetch skid buffer
//   HALT          : opcode that stops instruction fetch
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SKID   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;
  } ifid_t;

  localparam opcode_t HALT = 6'h3F;

endpackage

// File: rtl/ifid_latch.sv
// Pipeline register holding one ifid_t entry with load / clear / hold.
// Serves as both the IF/ID register and the fetch skid buffer.
//   CLK, nRST : clock, asynchronous active-low reset
//   load      : capture d on the next rising edge
//   clear     : replace contents with a bubble (takes priority over load)
//   d         : entry to capture
//   q         : current entry
module ifid_latch
  import cpu_types_pkg::*;
#(
  parameter word_t CLEAR_INSTR = 32'h0
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load,
  input  logic  clear,
  input  ifid_t d,
  output ifid_t q
);

  localparam ifid_t BUBBLE = '{instr: CLEAR_INSTR, pc: '0, npc: '0, valid: 1'b0};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= BUBBLE;
    end else if (clear) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage between the PC and the IF/ID boundary.
// Requests instruction reads, strobes the PC, owns the IF/ID register plus a
// one-entry skid buffer so a fetched word survives a decode stall, squashes on
// flush, and stops fetching once a HALT enters IF/ID.
//   CLK, nRST      : clock, asynchronous active-low reset
//   imemaddr       : current PC
//   ihit, imemload : icache returns imemload this cycle
//   id_stall       : decode cannot accept a new IF/ID entry
//   flush          : redirect; squash IF/ID and skid
//   imemREN        : instruction read request
//   pc_enable, npc : PC update strobe and next sequential PC
//   ifid_*         : IF/ID register contents
//   fetch_halted   : fetch stopped on HALT
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter logic [5:0]  HALT_OPCODE = HALT,
  parameter logic [31:0] NOP_WORD    = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        id_stall,
  input  logic        flush,
  output logic        imemREN,
  output logic        pc_enable,
  output logic [31:0] npc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        fetch_halted
);

  fetch_state_t state, state_n;
  ifid_t        ifid_q, ifid_d, skid_q, fetched;
  logic         ifid_load, ifid_clear, skid_load, skid_clear;
  logic         pc_enable_raw;

  // 32-bit sum: the carry out is dropped, so the PC wraps modulo 2^32.
  assign npc     = imemaddr + PC_STEP;
  assign fetched = '{instr: imemload, pc: imemaddr, npc: npc, valid: 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Rule-priority mux: flush first, then the per-state behaviour.
  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n       = state;
    ifid_d        = fetched;
    ifid_load     = 1'b0;
    ifid_clear    = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    pc_enable_raw = 1'b0;

    if (flush) begin
      ifid_clear    = 1'b1;
      skid_clear    = 1'b1;
      pc_enable_raw = 1'b1;
      state_n       = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (ihit && !id_stall) begin
            ifid_load     = 1'b1;
            pc_enable_raw = 1'b1;
            if (imemload[31:26] == HALT_OPCODE) state_n = HALTED;
          end else if (ihit) begin
            // Word already consumed from the PC's point of view: park it.
            skid_load     = 1'b1;
            pc_enable_raw = 1'b1;
            state_n       = SKID;
          end else if (!id_stall) begin
            ifid_clear = 1'b1;
          end
        end
        SKID: begin
          if (!id_stall) begin
            // The skid entry was captured with valid=1.
            ifid_d     = skid_q;
            ifid_load  = 1'b1;
            skid_clear = 1'b1;
            state_n    = (skid_q.instr[31:26] == HALT_OPCODE) ? HALTED : RUN;
          end
        end
        HALTED: begin
          if (!id_stall) ifid_clear = 1'b1;
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

  ifid_latch #(.CLEAR_INSTR(NOP_WORD)) u_ifid (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (ifid_load),
    .clear (ifid_clear),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  ifid_latch #(.CLEAR_INSTR(NOP_WORD)) u_skid (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (fetched),
    .q     (skid_q)
  );

  assign imemREN      = (state == RUN);
  assign pc_enable    = pc_enable_raw && nRST;
  assign fetch_halted = (state == HALTED);
  assign ifid_instr   = ifid_q.instr;
  assign ifid_pc      = ifid_q.pc;
  assign ifid_npc     = ifid_q.npc;
  assign ifid_valid   = ifid_q.valid;

endmodule
